// File: rtl/ysyx_22050710_sram_arbiter_pkg.sv
// ============================================================================
// Module : ysyx_22050710_sram_arbiter_pkg
// Brief  : Shared arbitration-mode encodings and channel-id width helper.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ysyx_22050710_sram_arbiter_pkg;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  function automatic int ch_id_wd(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_22050710_id_fifo.sv
// ============================================================================
// Module : ysyx_22050710_id_fifo
// Brief  : Small sync FIFO of channel ids; depth need not be a power of two.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ysyx_22050710_id_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_id,
  input  logic                       i_pop,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic [WIDTH-1:0]           o_head
);

  localparam int CNT_WD = $clog2(DEPTH + 1);
  localparam int PTR_WD = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [PTR_WD-1:0] r_wr_ptr;
  logic [PTR_WD-1:0] r_rd_ptr;
  logic [CNT_WD-1:0] r_count;
  logic              w_push;
  logic              w_pop;

  function automatic logic [PTR_WD-1:0] ptr_inc(input logic [PTR_WD-1:0] p);
    return (p == PTR_WD'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full  = (r_count == CNT_WD'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the head is only consumed while the count is non-zero.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_id;
  end

endmodule

`default_nettype wire

// File: rtl/ysyx_22050710_sram_arbiter.sv
// ============================================================================
// Module : ysyx_22050710_sram_arbiter
// Brief  : N-channel SRAM-like arbiter with in-order response routing.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ysyx_22050710_sram_arbiter
  import ysyx_22050710_sram_arbiter_pkg::*;
#(
  parameter int N_CH          = 2,
  parameter int SRAM_ADDR_WD  = 32,
  parameter int SRAM_WMASK_WD = 8,
  parameter int SRAM_DATA_WD  = 64,
  parameter int OUTSTANDING   = 4,
  parameter int ARB_MODE      = 0
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [N_CH-1:0]                  i_m_req,
  input  logic [N_CH-1:0]                  i_m_op,
  input  logic [2*N_CH-1:0]                i_m_size,
  input  logic [N_CH*SRAM_ADDR_WD-1:0]     i_m_addr,
  input  logic [N_CH*SRAM_WMASK_WD-1:0]    i_m_wstrb,
  input  logic [N_CH*SRAM_DATA_WD-1:0]     i_m_wdata,
  output logic [N_CH-1:0]                  o_m_addr_ok,
  output logic [N_CH-1:0]                  o_m_data_ok,
  output logic [SRAM_DATA_WD-1:0]          o_m_rdata,
  output logic                             o_s_req,
  output logic                             o_s_op,
  output logic [1:0]                       o_s_size,
  output logic [SRAM_ADDR_WD-1:0]          o_s_addr,
  output logic [SRAM_WMASK_WD-1:0]         o_s_wstrb,
  output logic [SRAM_DATA_WD-1:0]          o_s_wdata,
  input  logic                             i_s_addr_ok,
  input  logic                             i_s_data_ok,
  input  logic [SRAM_DATA_WD-1:0]          i_s_rdata,
  output logic [$clog2(OUTSTANDING+1)-1:0] o_outstanding,
  output logic                             o_err_unexp
);

  localparam int CH_ID_WD = ch_id_wd(N_CH);
  localparam int CNT_WD   = $clog2(OUTSTANDING + 1);

  logic                r_locked;
  logic [CH_ID_WD-1:0] r_lock_ch;
  logic [CH_ID_WD-1:0] r_rr_ptr;
  logic                r_err;

  logic [CH_ID_WD-1:0] w_start;
  logic                w_grant_vld;
  logic [CH_ID_WD-1:0] w_grant_id;
  logic                w_s_req;
  logic                w_hs;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [CNT_WD-1:0]   w_count;
  logic [CH_ID_WD-1:0] w_head;

  assign w_start = (ARB_MODE == ARB_RR) ? r_rr_ptr : '0;

  // Scan from the lowest-priority offset downwards so the nearest requester wins.
  always_comb begin
    int idx;
    idx         = 0;
    w_grant_vld = 1'b0;
    w_grant_id  = '0;
    if (r_locked) begin
      w_grant_vld = 1'b1;
      w_grant_id  = r_lock_ch;
    end else begin
      for (int i = N_CH - 1; i >= 0; i--) begin
        idx = (int'(w_start) + i) % N_CH;
        if (i_m_req[idx]) begin
          w_grant_vld = 1'b1;
          w_grant_id  = CH_ID_WD'(idx);
        end
      end
    end
  end

  // Reset gates the request so nothing leaks to the slave while held in reset.
  assign w_s_req = i_rst_n & w_grant_vld & ~w_full;
  assign w_hs    = w_s_req & i_s_addr_ok;
  assign w_pop   = i_s_data_ok & ~w_empty;

  assign o_s_req     = w_s_req;
  assign o_s_op      = w_s_req & i_m_op[w_grant_id];
  assign o_s_size    = w_s_req ? i_m_size[int'(w_grant_id)*2 +: 2] : '0;
  assign o_s_addr    = w_s_req ? i_m_addr[int'(w_grant_id)*SRAM_ADDR_WD +: SRAM_ADDR_WD] : '0;
  assign o_s_wstrb   = w_s_req ? i_m_wstrb[int'(w_grant_id)*SRAM_WMASK_WD +: SRAM_WMASK_WD] : '0;
  assign o_s_wdata   = w_s_req ? i_m_wdata[int'(w_grant_id)*SRAM_DATA_WD +: SRAM_DATA_WD] : '0;
  assign o_m_addr_ok = w_hs ? (N_CH'(1) << w_grant_id) : '0;
  assign o_m_data_ok = w_pop ? (N_CH'(1) << w_head) : '0;
  assign o_m_rdata   = w_pop ? i_s_rdata : '0;
  assign o_outstanding = w_count;
  assign o_err_unexp   = r_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_locked  <= 1'b0;
      r_lock_ch <= '0;
      r_rr_ptr  <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_hs) begin
        r_locked <= 1'b0;
        r_rr_ptr <= (w_grant_id == CH_ID_WD'(N_CH - 1)) ? '0 : w_grant_id + 1'b1;
      end else if (w_s_req) begin
        r_locked  <= 1'b1;
        r_lock_ch <= w_grant_id;
      end
      if (i_s_data_ok && w_empty) r_err <= 1'b1;
    end
  end

  ysyx_22050710_id_fifo #(
    .WIDTH (CH_ID_WD),
    .DEPTH (OUTSTANDING)
  ) u_id_fifo (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_push    (w_hs),
    .i_push_id (w_grant_id),
    .i_pop     (w_pop),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (w_count),
    .o_head    (w_head)
  );

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22050710_sram_arbiter.sv
// ============================================================================
// Module : tb_ysyx_22050710_sram_arbiter
// Brief  : Directed vector table plus hand sequences for reset and fixed priority.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ysyx_22050710_sram_arbiter;

  logic         clk;
  logic         rst_n;
  logic [1:0]   m_req;
  logic [1:0]   m_op;
  logic [3:0]   m_size;
  logic [63:0]  m_addr;
  logic [15:0]  m_wstrb;
  logic [127:0] m_wdata;
  logic         s_addr_ok;
  logic         s_data_ok;
  logic [63:0]  s_rdata;

  logic [1:0]  rr_addr_ok, rr_data_ok, fx_addr_ok, fx_data_ok;
  logic [63:0] rr_rdata, fx_rdata, rr_s_wdata, fx_s_wdata;
  logic        rr_s_req, rr_s_op, fx_s_req, fx_s_op;
  logic [1:0]  rr_s_size, fx_s_size;
  logic [31:0] rr_s_addr, fx_s_addr;
  logic [7:0]  rr_s_wstrb, fx_s_wstrb;
  logic [2:0]  rr_cnt, fx_cnt;
  logic        rr_err, fx_err;

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ysyx_22050710_sram_arbiter #(.ARB_MODE(0)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_m_req(m_req), .i_m_op(m_op), .i_m_size(m_size),
    .i_m_addr(m_addr), .i_m_wstrb(m_wstrb), .i_m_wdata(m_wdata),
    .o_m_addr_ok(rr_addr_ok), .o_m_data_ok(rr_data_ok), .o_m_rdata(rr_rdata),
    .o_s_req(rr_s_req), .o_s_op(rr_s_op), .o_s_size(rr_s_size), .o_s_addr(rr_s_addr),
    .o_s_wstrb(rr_s_wstrb), .o_s_wdata(rr_s_wdata),
    .i_s_addr_ok(s_addr_ok), .i_s_data_ok(s_data_ok), .i_s_rdata(s_rdata),
    .o_outstanding(rr_cnt), .o_err_unexp(rr_err)
  );

  ysyx_22050710_sram_arbiter #(.ARB_MODE(1)) dut_fx (
    .i_clk(clk), .i_rst_n(rst_n), .i_m_req(m_req), .i_m_op(m_op), .i_m_size(m_size),
    .i_m_addr(m_addr), .i_m_wstrb(m_wstrb), .i_m_wdata(m_wdata),
    .o_m_addr_ok(fx_addr_ok), .o_m_data_ok(fx_data_ok), .o_m_rdata(fx_rdata),
    .o_s_req(fx_s_req), .o_s_op(fx_s_op), .o_s_size(fx_s_size), .o_s_addr(fx_s_addr),
    .o_s_wstrb(fx_s_wstrb), .o_s_wdata(fx_s_wdata),
    .i_s_addr_ok(s_addr_ok), .i_s_data_ok(s_data_ok), .i_s_rdata(s_rdata),
    .o_outstanding(fx_cnt), .o_err_unexp(fx_err)
  );

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  op;
    logic [31:0] a0;
    logic [31:0] a1;
    logic        aok;
    logic        dok;
    logic [63:0] rd;
    logic        e_sreq;
    logic [31:0] e_saddr;
    logic        e_sop;
    logic [1:0]  e_aok;
    logic [1:0]  e_dok;
    logic [63:0] e_rd;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic [1:0] req, input logic [1:0] op, input logic [31:0] a0, input logic [31:0] a1,
    input logic aok, input logic dok, input logic [63:0] rd,
    input logic e_sreq, input logic [31:0] e_saddr, input logic e_sop,
    input logic [1:0] e_aok, input logic [1:0] e_dok, input logic [63:0] e_rd,
    input logic [2:0] e_cnt);
    vec_t v;
    v.req = req; v.op = op; v.a0 = a0; v.a1 = a1; v.aok = aok; v.dok = dok; v.rd = rd;
    v.e_sreq = e_sreq; v.e_saddr = e_saddr; v.e_sop = e_sop; v.e_aok = e_aok;
    v.e_dok = e_dok; v.e_rd = e_rd; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    m_req = 2'b00; m_op = 2'b00; m_addr = '0;
    s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    m_size  = {2'd2, 2'd3};
    m_wstrb = {8'hF0, 8'h0F};
    m_wdata = {64'hB1B1_B1B1_B1B1_B1B1, 64'hA0A0_A0A0_A0A0_A0A0};
    drive_idle();
    rst_n = 1'b0;

    // Outputs held at zero in reset even with a live request.
    @(negedge clk);
    m_req = 2'b01; m_addr = {32'h0, 32'h1234}; s_addr_ok = 1'b1;
    #1;
    check("rst s_req", rr_s_req, 0);
    check("rst addr_ok", rr_addr_ok, 0);
    check("rst cnt", rr_cnt, 0);
    check("rst err", rr_err, 0);
    check("rst s_addr", rr_s_addr, 0);
    do_reset();

    // Round-robin, full, lock across a pop, in-order routing
    tbl.push_back(mk(2'b11, 2'b10, 32'h1000, 32'h2000, 1, 0, 0,        1, 32'h1000, 0, 2'b01, 2'b00, 0, 0));
    tbl.push_back(mk(2'b11, 2'b10, 32'h1000, 32'h2000, 1, 0, 0,        1, 32'h2000, 1, 2'b10, 2'b00, 0, 1));
    tbl.push_back(mk(2'b11, 2'b10, 32'h1000, 32'h2000, 1, 0, 0,        1, 32'h1000, 0, 2'b01, 2'b00, 0, 2));
    tbl.push_back(mk(2'b11, 2'b10, 32'h1000, 32'h2000, 1, 0, 0,        1, 32'h2000, 1, 2'b10, 2'b00, 0, 3));
    tbl.push_back(mk(2'b11, 2'b10, 32'h1000, 32'h2000, 1, 0, 0,        0, 32'h0,    0, 2'b00, 2'b00, 0, 4));
    tbl.push_back(mk(2'b11, 2'b10, 32'h1000, 32'h2000, 0, 1, 64'h11,   0, 32'h0,    0, 2'b00, 2'b01, 64'h11, 4));
    tbl.push_back(mk(2'b11, 2'b10, 32'h1000, 32'h2000, 0, 0, 0,        1, 32'h1000, 0, 2'b00, 2'b00, 0, 3));
    tbl.push_back(mk(2'b11, 2'b10, 32'h1000, 32'h2000, 1, 1, 64'h22,   1, 32'h1000, 0, 2'b01, 2'b10, 64'h22, 3));
    tbl.push_back(mk(2'b00, 2'b00, 32'h0,    32'h0,    0, 1, 64'h33,   0, 32'h0,    0, 2'b00, 2'b01, 64'h33, 3));
    tbl.push_back(mk(2'b00, 2'b00, 32'h0,    32'h0,    0, 1, 64'h44,   0, 32'h0,    0, 2'b00, 2'b10, 64'h44, 2));
    tbl.push_back(mk(2'b00, 2'b00, 32'h0,    32'h0,    0, 1, 64'h55,   0, 32'h0,    0, 2'b00, 2'b01, 64'h55, 1));
    tbl.push_back(mk(2'b00, 2'b00, 32'h0,    32'h0,    0, 0, 0,        0, 32'h0,    0, 2'b00, 2'b00, 0, 0));
    // Single read, response three cycles after issue
    tbl.push_back(mk(2'b01, 2'b00, 32'h8000_0000, 32'h0, 1, 0, 0,      1, 32'h8000_0000, 0, 2'b01, 2'b00, 0, 0));
    tbl.push_back(mk(2'b00, 2'b00, 32'h0,    32'h0,    0, 0, 0,        0, 32'h0,    0, 2'b00, 2'b00, 0, 1));
    tbl.push_back(mk(2'b00, 2'b00, 32'h0,    32'h0,    0, 0, 0,        0, 32'h0,    0, 2'b00, 2'b00, 0, 1));
    tbl.push_back(mk(2'b00, 2'b00, 32'h0,    32'h0,    0, 1, 64'hDEADBEEF, 0, 32'h0, 0, 2'b00, 2'b01, 64'hDEADBEEF, 1));
    tbl.push_back(mk(2'b00, 2'b00, 32'h0,    32'h0,    0, 0, 0,        0, 32'h0,    0, 2'b00, 2'b00, 0, 0));
    // Move RR pointer to ch0, then ch1 holds a stalled request while ch0 arrives
    tbl.push_back(mk(2'b10, 2'b10, 32'h0,    32'h300,  1, 0, 0,        1, 32'h300,  1, 2'b10, 2'b00, 0, 0));
    tbl.push_back(mk(2'b00, 2'b00, 32'h0,    32'h0,    0, 1, 64'h66,   0, 32'h0,    0, 2'b00, 2'b10, 64'h66, 1));
    tbl.push_back(mk(2'b10, 2'b10, 32'h200,  32'h100,  0, 0, 0,        1, 32'h100,  1, 2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(2'b11, 2'b10, 32'h200,  32'h100,  0, 0, 0,        1, 32'h100,  1, 2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(2'b11, 2'b10, 32'h200,  32'h100,  0, 0, 0,        1, 32'h100,  1, 2'b00, 2'b00, 0, 0));
    tbl.push_back(mk(2'b11, 2'b10, 32'h200,  32'h100,  1, 0, 0,        1, 32'h100,  1, 2'b10, 2'b00, 0, 0));
    tbl.push_back(mk(2'b01, 2'b10, 32'h200,  32'h100,  1, 0, 0,        1, 32'h200,  0, 2'b01, 2'b00, 0, 1));
    tbl.push_back(mk(2'b00, 2'b00, 32'h0,    32'h0,    0, 1, 64'h77,   0, 32'h0,    0, 2'b00, 2'b10, 64'h77, 2));
    tbl.push_back(mk(2'b00, 2'b00, 32'h0,    32'h0,    0, 1, 64'h88,   0, 32'h0,    0, 2'b00, 2'b01, 64'h88, 1));
    tbl.push_back(mk(2'b00, 2'b00, 32'h0,    32'h0,    0, 0, 0,        0, 32'h0,    0, 2'b00, 2'b00, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      m_req = tbl[i].req; m_op = tbl[i].op; m_addr = {tbl[i].a1, tbl[i].a0};
      s_addr_ok = tbl[i].aok; s_data_ok = tbl[i].dok; s_rdata = tbl[i].rd;
      #1;
      check($sformatf("v%0d s_req", i),   rr_s_req,   tbl[i].e_sreq);
      check($sformatf("v%0d s_addr", i),  rr_s_addr,  tbl[i].e_saddr);
      check($sformatf("v%0d s_op", i),    rr_s_op,    tbl[i].e_sop);
      check($sformatf("v%0d addr_ok", i), rr_addr_ok, tbl[i].e_aok);
      check($sformatf("v%0d data_ok", i), rr_data_ok, tbl[i].e_dok);
      check($sformatf("v%0d rdata", i),   rr_rdata,   tbl[i].e_rd);
      check($sformatf("v%0d cnt", i),     rr_cnt,     tbl[i].e_cnt);
      check($sformatf("v%0d err", i),     rr_err,     0);
    end

    // Reset with two transactions in flight, then a stray response
    do_reset();
    @(negedge clk);
    m_req = 2'b01; m_addr = {32'h0, 32'h40}; s_addr_ok = 1'b1;
    #1 check("rm issue0 addr_ok", rr_addr_ok, 2'b01);
    @(negedge clk);
    #1 check("rm issue1 addr_ok", rr_addr_ok, 2'b01);
    check("rm cnt1", rr_cnt, 1);
    @(negedge clk);
    check("rm cnt2", rr_cnt, 2);
    rst_n = 1'b0;
    #1;
    check("rm rst cnt", rr_cnt, 0);
    check("rm rst s_req", rr_s_req, 0);
    check("rm rst addr_ok", rr_addr_ok, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive_idle();
    @(negedge clk);
    s_data_ok = 1'b1; s_rdata = 64'h99;
    #1;
    check("rm late data_ok", rr_data_ok, 2'b00);
    check("rm late rdata", rr_rdata, 0);
    check("rm err before", rr_err, 0);
    @(negedge clk);
    s_data_ok = 1'b0;
    #1;
    check("rm err sticky", rr_err, 1);
    check("rm cnt after", rr_cnt, 0);

    // Fixed priority: ch0 wins until it drops its request
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      m_req = 2'b11; m_op = 2'b10; m_addr = {32'h2000, 32'h1000}; s_addr_ok = 1'b1;
      #1;
      check($sformatf("fx%0d addr_ok", k), fx_addr_ok, 2'b01);
      check($sformatf("fx%0d s_addr", k), fx_s_addr, 32'h1000);
      check($sformatf("fx%0d s_wdata", k), fx_s_wdata, 64'hA0A0_A0A0_A0A0_A0A0);
    end
    @(negedge clk);
    m_req = 2'b10;
    #1;
    check("fx ch1 addr_ok", fx_addr_ok, 2'b10);
    check("fx ch1 size", fx_s_size, 2'd2);
    check("fx ch1 wstrb", fx_s_wstrb, 8'hF0);
    check("fx ch1 op", fx_s_op, 1);
    check("fx cnt", fx_cnt, 3);
    @(negedge clk);
    drive_idle();
    #1 check("fx full cnt", fx_cnt, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
